// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the program-memory image loader.
package imem_loader_pkg;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_MAX_WORDS = 4096;
  localparam int HDR_W         = 16;
  localparam int CSUM_W        = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs MSB-first bytes into 32-bit words; word_valid pulses the cycle after the 4th byte.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        valid_in,
  output logic [31:0] word_out,
  output logic        word_valid
);

  logic [23:0] shift_reg;
  logic [1:0]  cnt_reg;
  logic [31:0] word_reg;
  logic        valid_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      // The last written word is kept across a new load; only reset zeroes it.
      if (reset) begin
        word_reg <= '0;
      end
    end else begin
      valid_reg <= 1'b0;
      if (valid_in) begin
        shift_reg <= {shift_reg[15:0], byte_in};
        cnt_reg   <= cnt_reg + 2'd1;
        if (cnt_reg == 2'd3) begin
          word_reg  <= {shift_reg, byte_in};
          valid_reg <= 1'b1;
        end
      end
    end
  end

  assign word_out   = word_reg;
  assign word_valid = valid_reg;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into program memory and
// releases the downstream core only after a good load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state_reg, state_next;

  logic [7:0]        hdr_hi_reg;
  logic [HDR_W-1:0]  n_words_reg;
  logic [HDR_W-1:0]  word_cnt_reg;
  logic [1:0]        byte_cnt_reg;
  logic [CSUM_W-1:0] csum_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic             accept;
  logic             start_ok;
  logic [HDR_W-1:0] hdr_n;
  logic             hdr_bad;
  logic             last_byte;

  assign accept    = rx_valid && rx_ready;
  assign hdr_n     = {hdr_hi_reg, rx_data};
  assign hdr_bad   = (hdr_n == '0) || ({16'd0, hdr_n} > 32'(MAX_WORDS));
  assign last_byte = (byte_cnt_reg == 2'd3) && (word_cnt_reg == n_words_reg - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_reset  = 1'b1;
    start_ok   = 1'b0;
    case (state_reg)
      IDLE, DONE, ERROR: begin
        done      = (state_reg == DONE);
        err       = (state_reg == ERROR);
        cpu_reset = (state_reg != DONE);
        if (start) begin
          start_ok   = 1'b1;
          state_next = HDR_HI;
        end
      end
      HDR_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_next = HDR_LO;
      end
      HDR_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_next = hdr_bad ? ERROR : DATA;
      end
      DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last_byte) state_next = CSUM;
      end
      CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_next = (rx_data == csum_reg) ? DONE : ERROR;
      end
      default: state_next = IDLE;
    endcase
  end

  // imem_addr is captured alongside the assembler's word so both land in the write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_hi_reg   <= '0;
      n_words_reg  <= '0;
      word_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      csum_reg     <= '0;
      addr_reg     <= '0;
    end else begin
      if (start_ok) begin
        word_cnt_reg <= '0;
        byte_cnt_reg <= '0;
        csum_reg     <= '0;
      end
      if (accept) begin
        case (state_reg)
          HDR_HI: hdr_hi_reg  <= rx_data;
          HDR_LO: n_words_reg <= hdr_n;
          DATA: begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            csum_reg     <= csum_reg ^ rx_data;
            if (byte_cnt_reg == 2'd3) begin
              word_cnt_reg <= word_cnt_reg + 16'd1;
              addr_reg     <= word_cnt_reg[ADDR_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_in    (rx_data),
    .valid_in   (accept && (state_reg == DATA)),
    .word_out   (imem_wdata),
    .word_valid (imem_we)
  );

  assign imem_addr = addr_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes queued as stimulus is driven,
// popped and compared by a write monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] img[0:1];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_wr_cyc = -100;
  int wr_gap      = 0;
  int wr_total    = 0;
  int wr_base     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_t e;
      wr_gap      = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
      wr_total++;
      $display("write addr=%0h data=%h", imem_addr, imem_wdata);
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_write: observed addr %0h data %h expected no write", imem_addr, imem_wdata);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check32("wr_addr", 32'(imem_addr), 32'(e.addr));
        check32("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    check1("rx_ready", rx_ready, 1'b1);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [11:0] a);
    wr_t e;
    e.addr = a;
    e.data = w;
    sb.push_back(e);
    for (int j = 3; j >= 0; j--) send(w[8*j +: 8]);
  endtask

  task automatic load_words(input logic [15:0] n);
    send(n[15:8]);
    send(n[7:0]);
    for (int k = 0; k < int'(n); k++) send_word(img[k], 12'(k));
  endtask

  function automatic logic [7:0] img_csum(input int n);
    logic [7:0] x;
    x = '0;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) x = x ^ img[k][8*j +: 8];
    return x;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_rx_ready"}, rx_ready, 1'b0);
    check1({tag, "_imem_we"}, imem_we, 1'b0);
    check32({tag, "_imem_addr"}, 32'(imem_addr), 32'h0);
    check32({tag, "_imem_wdata"}, imem_wdata, 32'h0);
    check1({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_done"}, done, 1'b0);
    check1({tag, "_err"}, err, 1'b0);
  endtask

  task automatic check_end(input string tag, input logic exp_done, input int exp_writes);
    check1({tag, "_done"}, done, exp_done);
    check1({tag, "_err"}, err, !exp_done);
    check1({tag, "_cpu_reset"}, cpu_reset, !exp_done);
    check1({tag, "_busy"}, busy, 1'b0);
    check32({tag, "_writes"}, 32'(wr_total - wr_base), 32'(exp_writes));
    check32({tag, "_pending"}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    check_reset_outputs("por");
    reset = 1'b0;
    tick();
    check1("idle_busy", busy, 1'b0);

    // Single word 0x12345678, checksum 0x08
    img[0]  = 32'h12345678;
    wr_base = wr_total;
    pulse_start();
    check1("t1_busy", busy, 1'b1);
    check1("t1_cpu_reset", cpu_reset, 1'b1);
    load_words(16'd1);
    send(img_csum(1));
    check_end("t1", 1'b1, 1);

    // Two words back-to-back; the correct XOR checksum of these bytes is 0x55
    img[0]  = 32'h20080005;
    img[1]  = 32'h01095020;
    wr_base = wr_total;
    pulse_start();
    load_words(16'd2);
    send(img_csum(2));
    check32("t2_gap", 32'(wr_gap), 32'd4);
    check_end("t2", 1'b1, 2);

    // Same image with checksum byte 0x7D is rejected after both writes
    wr_base = wr_total;
    pulse_start();
    load_words(16'd2);
    send(8'h7D);
    check_end("t2b", 1'b0, 2);

    // Bad checksum on a single-word image
    img[0]  = 32'h12345678;
    wr_base = wr_total;
    pulse_start();
    load_words(16'd1);
    send(8'hFF);
    check_end("t3", 1'b0, 1);

    // Zero-length and oversize headers
    wr_base = wr_total;
    pulse_start();
    send(8'h00);
    send(8'h00);
    check1("t4a_rx_ready", rx_ready, 1'b0);
    check_end("t4a", 1'b0, 0);
    pulse_start();
    send(8'h10);
    send(8'h01);
    check_end("t4b", 1'b0, 0);

    // Reset in the middle of DATA, then a clean reload
    img[0]  = 32'h20080005;
    wr_base = wr_total;
    pulse_start();
    send(8'h00);
    send(8'h02);
    send_word(img[0], 12'd0);
    send(8'h01);
    reset = 1'b1;
    tick();
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    tick();
    tick();
    check32("t5_writes_after_rst", 32'(wr_total - wr_base), 32'd1);
    img[0]  = 32'h12345678;
    wr_base = wr_total;
    pulse_start();
    load_words(16'd1);
    send(img_csum(1));
    check_end("t5", 1'b1, 1);

    // start during DATA is ignored; start in DONE re-holds the core
    img[0]  = 32'h20080005;
    img[1]  = 32'h01095020;
    wr_base = wr_total;
    pulse_start();
    send(8'h00);
    send(8'h02);
    send_word(img[0], 12'd0);
    sb.push_back({12'd1, img[1]});
    start = 1'b1;
    send(img[1][31:24]);
    start = 1'b0;
    send(img[1][23:16]);
    send(img[1][15:8]);
    send(img[1][7:0]);
    send(img_csum(2));
    check_end("t6", 1'b1, 2);
    pulse_start();
    check1("t6_restart_cpu_reset", cpu_reset, 1'b1);
    check1("t6_restart_busy", busy, 1'b1);
    check1("t6_restart_done", done, 1'b0);
    img[0]  = 32'h12345678;
    wr_base = wr_total;
    load_words(16'd1);
    send(img_csum(1));
    check_end("t6b", 1'b1, 1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
